// File: rtl/serial_alu_sequencer.sv
// Bit-serial WIDTH-bit ALU controller: streams latched operands LSB-first through an
// external one-bit ALU slice, recirculates its carry and assembles the result and flags.
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic [1:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_a_invert,
  output logic             alu_b_invert,
  output logic [1:0]       alu_operation,
  output logic             alu_carry_in,
  input  logic             alu_result,
  input  logic             alu_carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             a_inv_q, a_inv_d;
  logic             b_inv_q, b_inv_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    a_inv_d   = a_inv_q;
    b_inv_d   = b_inv_q;
    op_d      = op_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          a_inv_d = a_invert;
          b_inv_d = b_invert;
          // The reserved encoding is folded onto AND at latch time.
          op_d    = (operation == 2'b11) ? 2'b00 : operation;
          carry_d = b_invert;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        res_sh_d = {alu_result, res_sh_q[WIDTH-1:1]};
        carry_d  = alu_carry_out;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cin_msb_d = carry_q;
          state_d   = S_DONE;
        end else begin
          state_d   = S_RUN;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = res_sh_q;
        zero_d   = (res_sh_q == '0);
        cout_d   = (op_q == 2'b10) ? carry_q : 1'b0;
        ovf_d    = (op_q == 2'b10) ? (carry_q ^ cin_msb_q) : 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      a_inv_q   <= 1'b0;
      b_inv_q   <= 1'b0;
      op_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      a_inv_q   <= a_inv_d;
      b_inv_q   <= b_inv_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign carry_out     = cout_q;
  assign overflow      = ovf_q;
  // Slice data inputs are quiet outside RUN; controls always mirror the latched values.
  assign alu_a         = (state_q == S_RUN) & a_sh_q[0];
  assign alu_b         = (state_q == S_RUN) & b_sh_q[0];
  assign alu_carry_in  = (state_q == S_RUN) & carry_q;
  assign alu_a_invert  = a_inv_q;
  assign alu_b_invert  = b_inv_q;
  assign alu_operation = op_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer with a behavioural one-bit ALU slice.
module tb_serial_alu_sequencer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, a_invert, b_invert;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       operation;
  logic             busy, done, zero, carry_out, overflow;
  logic [WIDTH-1:0] result;
  logic             alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in;
  logic [1:0]       alu_operation;
  logic             alu_result, alu_carry_out;

  always #5 clk = ~clk;

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .a_invert(a_invert), .b_invert(b_invert), .operation(operation),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .overflow(overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_a_invert(alu_a_invert),
    .alu_b_invert(alu_b_invert), .alu_operation(alu_operation),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .alu_carry_out(alu_carry_out)
  );

  // One-bit ALU slice
  logic sa, sb_bit;
  assign sa            = alu_a ^ alu_a_invert;
  assign sb_bit        = alu_b ^ alu_b_invert;
  assign alu_carry_out = (sa & sb_bit) | (sa & alu_carry_in) | (sb_bit & alu_carry_in);
  assign alu_result    = (alu_operation == 2'b01) ? (sa | sb_bit) :
                         (alu_operation == 2'b10) ? (sa ^ sb_bit ^ alu_carry_in) :
                                                    (sa & sb_bit);

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z, c, v;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pcnt = 0;
  logic [WIDTH-1:0] last_res;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ai, input logic bi, input logic [1:0] op);
    exp_t e;
    logic [WIDTH-1:0] x, y;
    int ux, uy, sx, sy, s;
    x = ai ? ~a : a;
    y = bi ? ~b : b;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      2'b01: e.res = x | y;
      2'b10: begin
        ux = int'(x); uy = int'(y);
        s = ux + uy + int'(bi);
        e.res = s[WIDTH-1:0];
        e.c = (s >= (1 << WIDTH));
        sx = (ux >= (1 << (WIDTH-1))) ? ux - (1 << WIDTH) : ux;
        sy = (uy >= (1 << (WIDTH-1))) ? uy - (1 << WIDTH) : uy;
        s = sx + sy + int'(bi);
        e.v = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
      end
      default: e.res = x & y;
    endcase
    e.z = (e.res == '0);
    e.due = 0;
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest expectation, flags missing ones.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_latency", pcnt, e.due);
          check("result", result, e.res);
          check("zero", zero, e.z);
          check("carry_out", carry_out, e.c);
          check("overflow", overflow, e.v);
        end
      end else if (sb.size() != 0 && pcnt >= sb[0].due) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done expected done at edge %0d (t=%0t)", e.due, $time);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ai, input logic bi, input logic [1:0] op);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; a_invert = ai; b_invert = bi; operation = op;
    e = model(a, b, ai, bi, op);
    e.due = pcnt + WIDTH + 2;
    sb.push_back(e);
    last_res = e.res;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    a_invert = 1'($urandom); b_invert = 1'($urandom); operation = 2'($urandom);
    check("busy_run", busy, 1'b1);
    check("alu_operation", alu_operation, (op == 2'b11) ? 2'b00 : op);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("result_hold", result, last_res);
    check("busy_idle", busy, 1'b0);
    check("alu_cin_idle", alu_carry_in, 1'b0);
  endtask

  typedef struct { logic [7:0] a, b; logic ai, bi; logic [1:0] op; } vec_t;
  vec_t dir[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    a_invert = 1'b0; b_invert = 1'b0; operation = 2'b00;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry_out, overflow}, 3'b000);
    check("rst_alu", {alu_a, alu_b, alu_carry_in, alu_a_invert, alu_b_invert, alu_operation}, 7'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    dir = '{ '{8'h05, 8'h03, 1'b0, 1'b0, 2'b10}, '{8'h03, 8'h05, 1'b0, 1'b1, 2'b10},
             '{8'h05, 8'h03, 1'b0, 1'b1, 2'b10}, '{8'h7F, 8'h01, 1'b0, 1'b0, 2'b10},
             '{8'hFF, 8'h01, 1'b0, 1'b0, 2'b10}, '{8'hF0, 8'h0F, 1'b0, 1'b0, 2'b00},
             '{8'h00, 8'h00, 1'b1, 1'b1, 2'b00}, '{8'hA5, 8'h5A, 1'b0, 1'b0, 2'b01},
             '{8'hF3, 8'h3C, 1'b0, 1'b0, 2'b11}, '{8'h80, 8'h80, 1'b0, 1'b0, 2'b10} };
    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].ai, dir[i].bi, dir[i].op);
      wait_idle();
    end

    for (int i = 0; i < 40; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      wait_idle();
    end

    // Start while running must be ignored.
    issue(8'h12, 8'h34, 1'b0, 1'b0, 2'b10);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; operation = 2'b01;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (15) @(posedge clk);

    // Reset in the middle of RUN aborts.
    issue(8'h21, 8'h43, 1'b0, 1'b0, 2'b10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 2'b10);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
